// File: rtl/layer_sequencer.sv
// Steps the weight-stationary array through C1,S2,C3,S4,C5,FC, issuing each layer's passes in order.
// Each layer gets a 2-cycle setup with a cal-state handshake check; abort returns to idle at once.
module layer_sequencer #(
  parameter int C1_PASSES = 6,
  parameter int S2_PASSES = 6,
  parameter int C3_PASSES = 16,
  parameter int S4_PASSES = 16,
  parameter int C5_PASSES = 120,
  parameter int FC_PASSES = 84,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pass_done,
  input  logic [1:0]       i_cal_state,
  output logic [2:0]       o_layer,
  output logic             o_pass_start,
  output logic [CNT_W-1:0] o_pass_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ISSUE, ST_WAIT, ST_NEXT, ST_DONE
  } state_t;

  localparam logic [2:0] L_IDLE = 3'b000;
  localparam logic [2:0] L_C1   = 3'b001;
  localparam logic [2:0] L_S2   = 3'b010;
  localparam logic [2:0] L_C3   = 3'b011;
  localparam logic [2:0] L_S4   = 3'b100;
  localparam logic [2:0] L_C5   = 3'b101;
  localparam logic [2:0] L_FC   = 3'b111;

  // A zero pass count still runs one pass.
  function automatic logic [CNT_W-1:0] last_of(input int p);
    return (p <= 1) ? '0 : CNT_W'(p - 1);
  endfunction

  localparam logic [CNT_W-1:0] C1_LAST = last_of(C1_PASSES);
  localparam logic [CNT_W-1:0] S2_LAST = last_of(S2_PASSES);
  localparam logic [CNT_W-1:0] C3_LAST = last_of(C3_PASSES);
  localparam logic [CNT_W-1:0] S4_LAST = last_of(S4_PASSES);
  localparam logic [CNT_W-1:0] C5_LAST = last_of(C5_PASSES);
  localparam logic [CNT_W-1:0] FC_LAST = last_of(FC_PASSES);

  state_t           state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             setup_q, setup_d;

  logic [CNT_W-1:0] last_idx;
  logic [2:0]       next_layer;
  logic             cal_chk;
  logic [1:0]       cal_exp;

  always_comb begin
    last_idx   = FC_LAST;
    next_layer = L_IDLE;
    cal_chk    = 1'b0;
    cal_exp    = 2'b00;
    case (layer_q)
      L_C1: begin last_idx = C1_LAST; next_layer = L_S2; cal_chk = 1'b1; cal_exp = 2'b01; end
      L_S2: begin last_idx = S2_LAST; next_layer = L_C3; cal_chk = 1'b1; cal_exp = 2'b10; end
      L_C3: begin last_idx = C3_LAST; next_layer = L_S4; cal_chk = 1'b1; cal_exp = 2'b01; end
      L_S4: begin last_idx = S4_LAST; next_layer = L_C5; cal_chk = 1'b1; cal_exp = 2'b10; end
      L_C5: begin last_idx = C5_LAST; next_layer = L_FC; cal_chk = 1'b1; cal_exp = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    idx_d   = idx_q;
    err_d   = err_q;
    setup_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          err_d   = 1'b0;
          layer_d = L_C1;
          idx_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // The responder registers o_layer, so its answer is only valid on the second cycle.
        if (!setup_q) begin
          setup_d = 1'b1;
        end else if (cal_chk && (i_cal_state != cal_exp)) begin
          err_d   = 1'b1;
          layer_d = L_IDLE;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_pass_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q < last_idx) begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = ST_ISSUE;
        end else if (layer_q != L_FC) begin
          idx_d   = '0;
          layer_d = next_layer;
          state_d = ST_SETUP;
        end else begin
          idx_d   = '0;
          layer_d = L_IDLE;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        layer_d = L_IDLE;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    // Abort wins over every other event and leaves the error flag alone.
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      layer_d = L_IDLE;
      idx_d   = '0;
      err_d   = err_q;
      setup_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      layer_q <= L_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      setup_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      setup_q <= setup_d;
    end
  end

  assign o_layer      = layer_q;
  assign o_pass_idx   = idx_q;
  assign o_pass_start = (state_q == ST_ISSUE);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);
  assign o_err        = err_q;

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameters (name, default, meaning): C1_PASSES 6, pass count for C1; S2_PASSES 6, S2; C3_PASSES 16, C3; S4_PASSES 16, S4; C5_PASSES 120, C5; FC_PASSES 84, FC; CNT_W 8, pass counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start one full network run
- i_abort  in  1  abort the current run
- i_pass_done  in  1  one-cycle pulse from array: current pass finished
- i_cal_state  in  2  calculation state returned by the weight-stationary FSM
- o_layer  out  3  layer code driven to the weight-stationary FSM
- o_pass_start  out  1  one-cycle pulse launching a pass
- o_pass_idx  out  CNT_W  zero-based index of the current pass within the layer
- o_busy  out  1  run in progress
- o_done  out  1  one-cycle pulse, run completed
- o_err  out  1  sticky handshake error flag

Function
REQ-003 Layer codes: IDLE 000, C1 001, S2 010, C3 011, S4 100, C5 101, FC 111; fixed order C1, S2, C3, S4, C5, FC.
REQ-004 Expected i_cal_state: C1/C3/C5 01 (FULL), S2/S4 10 (PART); no check for FC.
REQ-005 States: ST_IDLE, ST_SETUP, ST_ISSUE, ST_WAIT, ST_NEXT, ST_DONE.
REQ-006 ST_IDLE: o_layer 000, o_busy 0; i_start=1 -> clear o_err, load layer C1, pass idx 0, go ST_SETUP.
REQ-007 ST_SETUP lasts exactly 2 cycles.
- o_layer holds the new code from the first cycle.
- On the second cycle, compare i_cal_state against the expected value (responder has 1-cycle register latency).
REQ-008 Setup mismatch (checked layers only): set o_err, drive o_layer 000, go ST_IDLE, no o_done.
REQ-009 ST_ISSUE: o_pass_start=1 for exactly one cycle, then ST_WAIT; i_pass_done during ST_ISSUE is ignored.
REQ-010 ST_WAIT: hold o_layer and o_pass_idx; i_pass_done=1 -> ST_NEXT; no timeout.
REQ-011 ST_NEXT (1 cycle):
- If pass idx < PASSES-1 for the layer: increment idx, go ST_ISSUE (no re-setup).
- Else if layer is not FC: idx 0, advance to next layer, go ST_SETUP.
- Else: go ST_DONE.
REQ-012 ST_DONE: o_done=1 for one cycle, o_layer 000, then ST_IDLE.
REQ-013 o_busy=1 in every state except ST_IDLE.
REQ-014 i_start while o_busy=1 is ignored.
REQ-015 i_abort=1 in any non-idle state:
- Next state ST_IDLE, o_layer 000, o_pass_idx 0.
- No o_done pulse; o_err unchanged.
- Abort has priority over all other events in the same cycle.
REQ-016 A pass-count parameter of 0 is treated as 1; the counter compares at CNT_W bits, and parameters SHALL fit in CNT_W.
REQ-017 o_err remains set until the next accepted i_start.

Reset
REQ-018 rst_n low, asynchronously and regardless of state: ST_IDLE, o_layer 000, o_pass_idx 0, o_pass_start 0, o_busy 0, o_done 0, o_err 0.
REQ-019 Reset mid-run discards all progress; the first run after release needs a fresh i_start.

Verification (bench uses all PASSES=2; responder model returns the expected cal state one cycle after o_layer changes)
REQ-020 Full run: i_start pulse, i_pass_done 3 cycles after each o_pass_start.
- o_layer steps 001,010,011,100,101,111.
- Exactly 12 o_pass_start pulses, with o_pass_idx 0,1 per layer.
- One o_done pulse, then o_layer 000 and o_busy 0.
REQ-021 Cal mismatch: responder returns 00 during S2 setup -> o_err=1, o_layer 000, o_busy 0, no o_done; next i_start clears o_err.
REQ-022 Abort: i_abort while waiting in C3 pass 1 -> next cycle ST_IDLE, o_layer 000, o_pass_idx 0, no o_done.
REQ-023 Early done: i_pass_done asserted in the same cycle as o_pass_start -> ignored; the FSM remains waiting until a later pulse.
REQ-024 Reset mid-run: rst_n low during C5 -> all outputs to reset values immediately; i_start while busy in a fresh run has no effect on sequence.
REQ-025 Default parameters: single run -> total o_pass_start count 248, o_pass_idx max 119 during C5.
